// File: rtl/ysyx_22041752_wb_stage_pkg.sv
// Shared widths, CSR indices, mstatus layout and the MS->WS bus struct for the write-back stage.
// Optional commit trace outputs are enabled by YSYX_22041752_DEBUG_TRACE_EN (see the top module).
package ysyx_22041752_wb_stage_pkg;

    localparam int ysyx_22041752_MS_TO_WS_BUS_WD = 300;
    localparam int ysyx_22041752_RF_DATA_WD      = 64;
    localparam int ysyx_22041752_RF_ADDR_WD      = 5;
    localparam int ysyx_22041752_INST_WD         = 32;

    localparam logic [1:0] ysyx_22041752_CSR_MSTATUS = 2'd0;
    localparam logic [1:0] ysyx_22041752_CSR_MTVEC   = 2'd1;
    localparam logic [1:0] ysyx_22041752_CSR_MEPC    = 2'd2;
    localparam logic [1:0] ysyx_22041752_CSR_MCAUSE  = 2'd3;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800;

    // Field order is MSB first, matching the packed bus from the memory stage.
    typedef struct packed {
        logic [63:0]                           pc;
        logic [ysyx_22041752_INST_WD-1:0]      inst;
        logic                                  rf_wen;
        logic [ysyx_22041752_RF_ADDR_WD-1:0]   rf_wnum;
        logic [ysyx_22041752_RF_DATA_WD-1:0]   rf_wdata;
        logic                                  exp;
        logic [63:0]                           exp_cause;
        logic                                  mret;
        logic                                  ebreak;
        logic                                  csr_wen;
        logic [1:0]                            csr_num;
        logic [63:0]                           csr_wdata;
    } ms_to_ws_t;

    function automatic logic [63:0] mstatus_trap(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [63:0] mstatus_mret(input logic [63:0] s);
        logic [63:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22041752_wb_stage_csr_file.sv
// Machine CSRs (mstatus/mtvec/mepc/mcause) with exp > mret > csr write update priority.
module ysyx_22041752_csr_file
    import ysyx_22041752_wb_stage_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         commit,
    input  logic         exp,
    input  logic [63:0]  exp_cause,
    input  logic [63:0]  pc,
    input  logic         mret,
    input  logic         csr_wen,
    input  logic [1:0]   csr_num,
    input  logic [63:0]  csr_wdata,
    output logic [63:0]  mtvec,
    output logic [63:0]  mepc,
    output logic [255:0] csr_rdata_bus
);

    logic [63:0] mstatus_q, mtvec_q, mepc_q, mcause_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mstatus_q <= MSTATUS_RST;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else if (commit) begin
            if (exp) begin
                mepc_q    <= pc;
                mcause_q  <= exp_cause;
                mstatus_q <= mstatus_trap(mstatus_q);
            end else if (mret) begin
                mstatus_q <= mstatus_mret(mstatus_q);
            end else if (csr_wen) begin
                case (csr_num)
                    ysyx_22041752_CSR_MSTATUS: mstatus_q <= csr_wdata;
                    ysyx_22041752_CSR_MTVEC:   mtvec_q   <= csr_wdata;
                    ysyx_22041752_CSR_MEPC:    mepc_q    <= csr_wdata;
                    default:                   mcause_q  <= csr_wdata;
                endcase
            end
        end
    end

    assign mtvec         = mtvec_q;
    assign mepc          = mepc_q;
    assign csr_rdata_bus = {mcause_q, mepc_q, mtvec_q, mstatus_q};

endmodule

// File: rtl/ysyx_22041752_wb_stage.sv
// Write-back stage: RF write, CSR ownership, exception/mret redirect and halt on ebreak.
// Define YSYX_22041752_DEBUG_TRACE_EN to drive the debug_wb_* commit trace outputs.
module ysyx_22041752_wb_stage
    import ysyx_22041752_wb_stage_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         ms_to_ws_valid,
    input  logic [ysyx_22041752_MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic         ws_allowin,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [63:0]  rf_wdata,
    output logic         ws_fwd_valid,
    output logic [4:0]   ws_fwd_num,
    output logic [63:0]  ws_fwd_data,
    output logic         ws_flush,
    output logic [63:0]  ws_flush_pc,
    output logic [255:0] csr_rdata_bus,
    output logic         ws_valid,
    output logic         stop,
    output logic [63:0]  debug_wb_pc,
    output logic         debug_wb_rf_wen,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [63:0]  debug_wb_rf_wdata
);

    ms_to_ws_t   in_bus, ws_q;
    logic        halted;
    logic        ws_ready_go;
    logic [63:0] mtvec, mepc;
    logic        unused_inst;

    assign in_bus      = ms_to_ws_t'(ms_to_ws_bus);
    assign unused_inst = ^ws_q.inst;
    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !halted && (!ws_valid || ws_ready_go);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
            halted   <= 1'b0;
            ws_q     <= '0;
        end else begin
            if (ws_allowin)
                ws_valid <= ms_to_ws_valid;
            else if (halted)
                ws_valid <= 1'b0;
            if (ms_to_ws_valid && ws_allowin)
                ws_q <= in_bus;
            // An excepting ebreak traps instead of halting.
            if (ws_valid && ws_q.ebreak && !ws_q.exp)
                halted <= 1'b1;
        end
    end

    assign rf_we    = ws_valid && ws_q.rf_wen && !ws_q.exp && (ws_q.rf_wnum != '0);
    assign rf_waddr = rf_we ? ws_q.rf_wnum  : '0;
    assign rf_wdata = rf_we ? ws_q.rf_wdata : '0;

    assign ws_fwd_valid = rf_we;
    assign ws_fwd_num   = rf_waddr;
    assign ws_fwd_data  = rf_wdata;

    // mtvec/mepc are the pre-update register values, so a same-cycle trap sees the old vector.
    assign ws_flush    = ws_valid && (ws_q.exp || ws_q.mret);
    assign ws_flush_pc = !ws_valid  ? '0    :
                         ws_q.exp   ? mtvec :
                         ws_q.mret  ? mepc  : '0;

    assign stop = halted;

    ysyx_22041752_csr_file u_csr (
        .clk           (clk),
        .resetn        (resetn),
        .commit        (ws_valid),
        .exp           (ws_q.exp),
        .exp_cause     (ws_q.exp_cause),
        .pc            (ws_q.pc),
        .mret          (ws_q.mret),
        .csr_wen       (ws_q.csr_wen),
        .csr_num       (ws_q.csr_num),
        .csr_wdata     (ws_q.csr_wdata),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .csr_rdata_bus (csr_rdata_bus)
    );

`ifdef YSYX_22041752_DEBUG_TRACE_EN
    // The latched pc only changes on a handshake, so it holds across idle cycles.
    assign debug_wb_pc       = ws_q.pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_wen   = 1'b0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_ysyx_22041752_wb_stage.sv
// Directed bench for the write-back stage: RF write, x0, trap/mret CSR effects, priority, streaming, halt.
module tb_ysyx_22041752_wb_stage;
    import ysyx_22041752_wb_stage_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ms_to_ws_valid;
    ms_to_ws_t    ms_to_ws_bus;
    logic         ws_allowin, rf_we, ws_fwd_valid, ws_flush, ws_valid, stop, debug_wb_rf_wen;
    logic [4:0]   rf_waddr, ws_fwd_num, debug_wb_rf_wnum;
    logic [63:0]  rf_wdata, ws_fwd_data, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
    logic [255:0] csr_rdata_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22041752_wb_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_valid      (ws_fwd_valid),
        .ws_fwd_num        (ws_fwd_num),
        .ws_fwd_data       (ws_fwd_data),
        .ws_flush          (ws_flush),
        .ws_flush_pc       (ws_flush_pc),
        .csr_rdata_bus     (csr_rdata_bus),
        .ws_valid          (ws_valid),
        .stop              (stop),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    function automatic ms_to_ws_t mk(input logic [63:0] pc, input logic wen,
                                     input logic [4:0] wnum, input logic [63:0] wdata);
        ms_to_ws_t b;
        b = '0;
        b.pc = pc; b.inst = 32'h0000_0013; b.rf_wen = wen; b.rf_wnum = wnum; b.rf_wdata = wdata;
        return b;
    endfunction

    function automatic ms_to_ws_t mk_csr(input logic [63:0] pc, input logic [1:0] num,
                                         input logic [63:0] wdata);
        ms_to_ws_t b;
        b = mk(pc, 1'b0, 5'd0, 64'd0);
        b.csr_wen = 1'b1; b.csr_num = num; b.csr_wdata = wdata;
        return b;
    endfunction

    // Presents one instruction for one cycle; returns #1 after the edge that loads it into WS.
    task automatic issue(input ms_to_ws_t b);
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = b;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ws_valid !== 1'b0) begin errors++; $display("FAIL reset_ws_valid got %0h exp 0", ws_valid); end
        checks++; if (stop !== 1'b0) begin errors++; $display("FAIL reset_stop got %0h exp 0", stop); end
        checks++; if ({rf_we, ws_fwd_valid, ws_flush, ws_flush_pc} !== '0) begin errors++;
            $display("FAIL reset_comb_outs got %0h/%0h/%0h/%0h exp 0", rf_we, ws_fwd_valid, ws_flush, ws_flush_pc); end
        checks++; if (csr_rdata_bus !== {192'd0, 64'h0000_000a_0000_1800}) begin errors++;
            $display("FAIL reset_csrs got %h exp mstatus a00001800 rest 0", csr_rdata_bus); end
        checks++; if (debug_wb_pc !== 64'd0) begin errors++; $display("FAIL reset_debug_pc got %h exp 0", debug_wb_pc); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_rf_write();
        issue(mk(64'h8000_0000, 1'b1, 5'd5, 64'h2a));
        checks++; if (ws_valid !== 1'b1) begin errors++; $display("FAIL addi_ws_valid got %0h exp 1", ws_valid); end
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h2a) begin errors++;
            $display("FAIL addi_rf got we=%0h a=%0d d=%h exp we=1 a=5 d=2a", rf_we, rf_waddr, rf_wdata); end
        checks++; if (ws_fwd_valid !== 1'b1 || ws_fwd_num !== 5'd5 || ws_fwd_data !== 64'h2a) begin errors++;
            $display("FAIL addi_fwd got v=%0h n=%0d d=%h exp v=1 n=5 d=2a", ws_fwd_valid, ws_fwd_num, ws_fwd_data); end
        checks++; if (ws_flush !== 1'b0) begin errors++; $display("FAIL addi_flush got %0h exp 0", ws_flush); end
`ifdef YSYX_22041752_DEBUG_TRACE_EN
        checks++; if (debug_wb_pc !== 64'h8000_0000 || debug_wb_rf_wen !== 1'b1 || debug_wb_rf_wnum !== 5'd5
                      || debug_wb_rf_wdata !== 64'h2a) begin errors++;
            $display("FAIL addi_debug got pc=%h wen=%0h n=%0d d=%h exp 80000000/1/5/2a",
                     debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata); end
        @(posedge clk); #1;
        checks++; if (ws_valid !== 1'b0 || debug_wb_pc !== 64'h8000_0000) begin errors++;
            $display("FAIL debug_pc_hold got v=%0h pc=%h exp 0/80000000", ws_valid, debug_wb_pc); end
`else
        checks++; if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0) begin errors++;
            $display("FAIL addi_debug_off got pc=%h wen=%0h exp 0", debug_wb_pc, debug_wb_rf_wen); end
`endif
    endtask

    task automatic test_x0();
        issue(mk(64'h8000_0004, 1'b1, 5'd0, 64'h1234));
        checks++; if (ws_valid !== 1'b1 || rf_we !== 1'b0 || ws_fwd_valid !== 1'b0) begin errors++;
            $display("FAIL x0_write got v=%0h we=%0h fwd=%0h exp 1/0/0", ws_valid, rf_we, ws_fwd_valid); end
    endtask

    task automatic test_exception();
        ms_to_ws_t b;
        issue(mk_csr(64'h8000_0008, ysyx_22041752_CSR_MSTATUS, 64'h0000_000a_0000_1808));
        issue(mk_csr(64'h8000_000c, ysyx_22041752_CSR_MTVEC, 64'h8000_0100));
        b = mk(64'h8000_0010, 1'b1, 5'd7, 64'h55);
        b.exp = 1'b1; b.exp_cause = 64'd11;
        issue(b);
        checks++; if (csr_rdata_bus[127:64] !== 64'h8000_0100) begin errors++;
            $display("FAIL csr_mtvec_write got %h exp 80000100", csr_rdata_bus[127:64]); end
        checks++; if (ws_flush !== 1'b1 || ws_flush_pc !== 64'h8000_0100) begin errors++;
            $display("FAIL exp_flush got f=%0h pc=%h exp 1/80000100", ws_flush, ws_flush_pc); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL exp_no_rf got %0h exp 0", rf_we); end
        @(posedge clk); #1;
        checks++; if (ws_flush !== 1'b0) begin errors++; $display("FAIL exp_flush_pulse got %0h exp 0", ws_flush); end
        checks++; if (csr_rdata_bus[191:128] !== 64'h8000_0010 || csr_rdata_bus[255:192] !== 64'd11) begin errors++;
            $display("FAIL exp_mepc_mcause got %h/%h exp 80000010/b", csr_rdata_bus[191:128], csr_rdata_bus[255:192]); end
        checks++; if (csr_rdata_bus[63:0] !== 64'h0000_000a_0000_1880) begin errors++;
            $display("FAIL exp_mstatus got %h exp a00001880", csr_rdata_bus[63:0]); end
    endtask

    task automatic test_mret();
        ms_to_ws_t b;
        b = mk(64'h8000_0200, 1'b0, 5'd0, 64'd0);
        b.mret = 1'b1;
        issue(b);
        checks++; if (ws_flush !== 1'b1 || ws_flush_pc !== 64'h8000_0010) begin errors++;
            $display("FAIL mret_flush got f=%0h pc=%h exp 1/80000010", ws_flush, ws_flush_pc); end
        @(posedge clk); #1;
        checks++; if (csr_rdata_bus[63:0] !== 64'h0000_000a_0000_0088) begin errors++;
            $display("FAIL mret_mstatus got %h exp a00000088", csr_rdata_bus[63:0]); end
        issue(mk_csr(64'h8000_0204, ysyx_22041752_CSR_MEPC, 64'h8000_0400));
        issue(b);
        checks++; if (ws_flush_pc !== 64'h8000_0400) begin errors++;
            $display("FAIL mret_new_mepc got %h exp 80000400", ws_flush_pc); end
    endtask

    task automatic test_priority();
        ms_to_ws_t b;
        b = mk(64'h8000_0300, 1'b1, 5'd9, 64'h77);
        b.exp = 1'b1; b.exp_cause = 64'd2; b.ebreak = 1'b1; b.mret = 1'b1;
        b.csr_wen = 1'b1; b.csr_num = ysyx_22041752_CSR_MTVEC; b.csr_wdata = 64'hdead;
        issue(b);
        checks++; if (ws_flush_pc !== 64'h8000_0100 || rf_we !== 1'b0) begin errors++;
            $display("FAIL prio_flush got pc=%h we=%0h exp 80000100/0", ws_flush_pc, rf_we); end
        @(posedge clk); #1;
        checks++; if (stop !== 1'b0 || ws_allowin !== 1'b1) begin errors++;
            $display("FAIL prio_no_halt got stop=%0h allowin=%0h exp 0/1", stop, ws_allowin); end
        checks++; if (csr_rdata_bus !== {64'd2, 64'h8000_0300, 64'h8000_0100, 64'h0000_000a_0000_1880}) begin errors++;
            $display("FAIL prio_csrs got %h exp cause 2 mepc 80000300 mtvec 80000100 mstatus a00001880", csr_rdata_bus); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int dbg_bad = 0;
        for (int i = 0; i < 100; i++) begin
            logic [4:0]  n;
            logic [63:0] d, p;
            logic        we;
            n = 5'(i % 32);
            d = 64'(i) * 64'h1111 + 64'd7;
            p = 64'h8000_1000 + 64'(4 * i);
            we = (n != 5'd0);
            @(negedge clk);
            ms_to_ws_valid = 1'b1;
            ms_to_ws_bus   = mk(p, 1'b1, n, d);
            @(posedge clk); #1;
            if (ws_valid !== 1'b1 || rf_we !== we || (we && (rf_waddr !== n || rf_wdata !== d))) begin
                bad++;
                if (bad == 1) $display("FAIL stream_rf i=%0d got v=%0h we=%0h a=%0d d=%h exp 1/%0h/%0d/%h",
                                       i, ws_valid, rf_we, rf_waddr, rf_wdata, we, n, d);
            end
`ifdef YSYX_22041752_DEBUG_TRACE_EN
            if (debug_wb_pc !== p || debug_wb_rf_wen !== we) dbg_bad++;
`else
            if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0) dbg_bad++;
`endif
        end
        @(negedge clk);
        ms_to_ws_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL stream_rf_total got %0d bad cycles exp 0", bad); end
        checks++; if (dbg_bad != 0) begin errors++; $display("FAIL stream_debug got %0d bad cycles exp 0", dbg_bad); end
    endtask

    task automatic test_halt();
        ms_to_ws_t b;
        b = mk(64'h8000_0500, 1'b0, 5'd0, 64'd0);
        b.ebreak = 1'b1;
        issue(b);
        checks++; if (ws_valid !== 1'b1 || stop !== 1'b0) begin errors++;
            $display("FAIL ebreak_commit got v=%0h stop=%0h exp 1/0", ws_valid, stop); end
        @(negedge clk);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus   = mk(64'h8000_0504, 1'b1, 5'd3, 64'h99);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (stop !== 1'b1 || ws_allowin !== 1'b0) begin errors++;
            $display("FAIL halt_sticky got stop=%0h allowin=%0h exp 1/0", stop, ws_allowin); end
        checks++; if (ws_valid !== 1'b0 || rf_we !== 1'b0) begin errors++;
            $display("FAIL halt_no_commit got v=%0h we=%0h exp 0/0", ws_valid, rf_we); end
        ms_to_ws_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if (stop !== 1'b0 || csr_rdata_bus[63:0] !== 64'h0000_000a_0000_1800) begin errors++;
            $display("FAIL halt_reset got stop=%0h mstatus=%h exp 0/a00001800", stop, csr_rdata_bus[63:0]); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rf_write();
        test_x0();
        test_exception();
        test_mret();
        test_priority();
        test_back_to_back();
        test_halt();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041752_wb_stage.md
# ysyx_22041752_wb_stage

Write-back stage of the 5-stage RV64 pipeline. It accepts retiring instructions from the memory stage, performs the register-file write, owns the machine CSRs (mstatus/mtvec/mepc/mcause), and raises the exception/mret redirect flush. It also drives the commit-debug signals consumed by the `dpi_c` trace block: `ws_valid`, `debug_wb_*`, `dpi_csrs`, and `stop`.

## Interface
Parameters (`ysyx_22041752_mycpu.vh`):
- `ysyx_22041752_MS_TO_WS_BUS_WD`, 300: width of the memory-to-write-back bus.
- `ysyx_22041752_RF_DATA_WD`, 64; `ysyx_22041752_RF_ADDR_WD`, 5; `ysyx_22041752_INST_WD`, 32.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ms_to_ws_valid` in 1: memory stage holds a valid instruction.
- `ms_to_ws_bus` in 300: {pc[63:0], inst[31:0], rf_wen, rf_wnum[4:0], rf_wdata[63:0], exp, exp_cause[63:0], mret, ebreak, csr_wen, csr_num[1:0], csr_wdata[63:0]}, MSB first.
- `ws_allowin` out 1: stage can accept an instruction this cycle.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 64: register-file write port.
- `ws_fwd_valid` out 1, `ws_fwd_num` out 5, `ws_fwd_data` out 64: forwarding to the decode stage.
- `ws_flush` out 1, `ws_flush_pc` out 64: front-end redirect.
- `csr_rdata_bus` out 256: {mcause, mepc, mtvec, mstatus} for CSR reads in EX. The same vector drives `dpi_csrs[3:0]`.
- `ws_valid` out 1, `stop` out 1.
- `debug_wb_pc` out 64, `debug_wb_rf_wen` out 1, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 64.

## Operation
- Handshake:
  - `ws_ready_go` = 1.
  - `ws_allowin` = !halted && (!ws_valid || ws_ready_go).
  - On `ws_allowin` the stage loads `ws_valid` <= `ms_to_ws_valid`.
  - The bus is latched only when `ms_to_ws_valid && ws_allowin`.
- Commit happens in the cycle `ws_valid` = 1. All effects are gated by `ws_valid`.
- RF write: `rf_we` = ws_valid && rf_wen && !exp && rf_wnum != 0.
- Forwarding: `ws_fwd_*` mirrors the RF write port combinationally.
- CSR index map: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause.
- CSR update priority is exp > mret > csr_wen. An excepting instruction performs no RF or CSR write.
  - exp: mepc <= pc; mcause <= exp_cause; mstatus.MPIE <= MIE; MIE <= 0; MPP <= 2'b11.
    - `ws_flush` = 1, `ws_flush_pc` = mtvec, using the value before this cycle's update.
  - mret: MIE <= MPIE; MPIE <= 1; MPP <= 2'b00.
    - `ws_flush` = 1, `ws_flush_pc` = mepc.
  - csr_wen: csr[csr_num] <= csr_wdata. A write to mtvec or mepc is visible to the next flush.
- Halt: committing `ebreak` sets the sticky `halted` flag, and `stop` = halted.
  - Once halted, `ws_allowin` = 0 and `ws_valid` clears on the next edge.
  - Only reset leaves the halted state.
- Reset values:
  - `ws_valid` 0, halted 0.
  - mstatus 64'h0000_000a_0000_1800; mtvec, mepc, mcause 0.
  - All combinational outputs evaluate to 0 under reset because `ws_valid` = 0.

## Timing
- Latency: one cycle from MS handshake to commit.
- RF write and CSR update take effect at the commit-cycle rising edge.
- `ws_flush` is combinational in the commit cycle and is a single-cycle pulse. MS/ES/DS/FS discard their contents on that edge.
- Back-to-back commits are allowed every cycle.
- Reset asserted mid-instruction drops it. No partial CSR update is possible because CSR updates are single-edge.
- ebreak together with exp: exp wins and `halted` is not set.

## Configuration
- `YSYX_22041752_DEBUG_TRACE_EN`
  - Defined: `debug_wb_pc`, `debug_wb_rf_*` follow the committing instruction. `debug_wb_pc` holds its last value when `ws_valid` = 0, and is 0 after reset.
  - Undefined: all `debug_wb_*` outputs are tied to 0 and their registers are removed. `stop`, `ws_valid` and the CSR bus are unaffected.

## Structure
- Shared header `ysyx_22041752_mycpu.vh` holds:
  - bus widths;
  - CSR index constants `ysyx_22041752_CSR_MSTATUS/MTVEC/MEPC/MCAUSE`;
  - the mstatus bit positions MIE=3, MPIE=7, MPP=12:11;
  - the mstatus reset constant.
- One sub-module, `ysyx_22041752_csr_file`. It holds the four CSRs and the priority update logic, and exports the 256-bit read bus.

## Test plan
- Reset release, then pc=0x80000000 with addi x5 (wdata 0x2a) → next cycle `rf_we`=1, waddr 5, wdata 0x2a, `debug_wb_pc`=0x80000000.
- rf_wen with wnum=0 → `rf_we`=0 and `ws_fwd_valid`=0.
- csr_wen mtvec=0x80000100, then exp on pc 0x80000010 with cause 11 → `ws_flush`=1, flush_pc 0x80000100, mepc 0x80000010, mcause 11, MIE=0, MPP=3, no RF write.
- mret after that → flush_pc 0x80000010, MIE = previous MPIE, MPIE=1, MPP=0.
- ebreak commit → `stop`=1 permanently, `ws_allowin`=0; asserting `resetn`=0 → `stop`=0 and mstatus 0xa00001800.
- Continuous valid stream of 100 instructions with the macro undefined → all `debug_wb_*` = 0, RF writes identical to the macro-defined run.
